dt_engine_param: RTL and testbench



---
 rtl/dt_engine_param_pkg.sv | 33 +++
 rtl/dt_engine_param_if.sv | 26 ++
 rtl/dt_engine_param_min_sat.sv | 29 ++
 rtl/dt_engine_param.sv | 236 +++++++++++++++++++++++
 tb/tb_dt_engine_param.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dt_engine_param_pkg.sv
// Shared types and arithmetic for the parametrised distance-transform engine.
package dt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD_FETCH,
    ST_FWD_RD,
    ST_FWD_WR,
    ST_BWD_RD,
    ST_BWD_WR,
    ST_FIN
  } dt_state_e;

  localparam logic MODE_CHESS = 1'b0;
  localparam logic MODE_CITY  = 1'b1;

  // min of four neighbours plus one, clamped to 2^w-1 (w <= 32)
  function automatic logic [31:0] sat_min_inc(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d,
                                              input int unsigned w);
    logic [31:0] m;
    logic [32:0] s;
    logic [32:0] lim;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    s   = {1'b0, m} + 33'd1;
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/dt_engine_param_if.sv
// ROM/RAM bus between the distance-transform engine and its memories.
interface dt_engine_param_if #(
  parameter int unsigned STI_AW = 10,
  parameter int unsigned STI_W  = 16,
  parameter int unsigned RES_AW = 14,
  parameter int unsigned DIST_W = 8
);
  logic              sti_rd;
  logic [STI_AW-1:0] sti_addr;
  logic [STI_W-1:0]  sti_di;
  logic              res_rd;
  logic              res_wr;
  logic [RES_AW-1:0] res_addr;
  logic [DIST_W-1:0] res_do;
  logic [DIST_W-1:0] res_di;

  modport master (
    output sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
    input  sti_di, res_di
  );

  modport slave (
    input  sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
    output sti_di, res_di
  );
endinterface

// File: rtl/dt_engine_param_min_sat.sv
// dt_min_sat: 4-input min, +1, clamp; diagonals masked off in city-block mode.
// Optional DT_SAT_FLAG_EN adds o_sat (result was clamped).
module dt_min_sat
  import dt_pkg::*;
#(
  parameter int unsigned DIST_W = 8
) (
  input  logic [DIST_W-1:0] i_a,
  input  logic [DIST_W-1:0] i_b,
  input  logic [DIST_W-1:0] i_c,
  input  logic [DIST_W-1:0] i_d,
  input  logic              i_city,
`ifdef DT_SAT_FLAG_EN
  output logic              o_sat,
`endif
  output logic [DIST_W-1:0] o_res
);
  logic [DIST_W-1:0] w_c;
  logic [DIST_W-1:0] w_d;

  assign w_c   = i_city ? '1 : i_c;
  assign w_d   = i_city ? '1 : i_d;
  assign o_res = DIST_W'(sat_min_inc(32'(i_a), 32'(i_b), 32'(w_c), 32'(w_d), DIST_W));

`ifdef DT_SAT_FLAG_EN
  // clamping happens exactly when every input already sits at the maximum
  assign o_sat = &{i_a, i_b, w_c, w_d};
`endif
endmodule

// File: rtl/dt_engine_param.sv
// Two-pass chessboard/city-block distance transform, sti ROM -> res RAM.
// Define DT_SAT_FLAG_EN to add the sticky sat_flag output.
module dt_engine_param
  import dt_pkg::*;
#(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned STI_W  = 16,
  parameter int unsigned DIST_W = 8,
  parameter int unsigned STI_AW = $clog2(IMG_W*IMG_H/STI_W),
  parameter int unsigned RES_AW = $clog2(IMG_W*IMG_H)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic busy,
  output logic done,
`ifdef DT_SAT_FLAG_EN
  output logic sat_flag,
`endif
  dt_engine_param_if.master mem
);
  localparam int unsigned CW = $clog2(IMG_W+1);
  localparam int unsigned RW = $clog2(IMG_H+1);
  localparam int unsigned BW = $clog2(STI_W+1);
  localparam logic [RES_AW-1:0] LP_W    = RES_AW'(IMG_W);
  localparam logic [RES_AW-1:0] LP_WM1  = RES_AW'(IMG_W-1);
  localparam logic [RES_AW-1:0] LP_LAST = RES_AW'(IMG_W*IMG_H-1);
  localparam logic [CW-1:0]     LP_CMAX = CW'(IMG_W-1);
  localparam logic [RW-1:0]     LP_RMAX = RW'(IMG_H-1);
  localparam logic [BW-1:0]     LP_BMAX = BW'(STI_W-1);

  dt_state_e r_state, w_next;
  logic [1:0]        r_phase, w_phase_nx;
  logic [RES_AW-1:0] r_pix;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [BW-1:0]     r_bit;
  logic [STI_AW-1:0] r_sti;
  logic [STI_W-1:0]  r_word;
  logic              r_mode, r_sti_pend, r_rd_pend, r_busy, r_done;
  logic [DIST_W-1:0] r_w, r_nw, r_n, r_own, r_s, r_e, r_se;
  logic [DIST_W-1:0] w_rdata, w_a, w_b, w_c, w_cand, w_new, w_fwd_val;
  logic              w_first_row, w_last_row, w_first_col, w_last_col;
  logic              w_first_pix, w_last_pix, w_obj;
`ifdef DT_SAT_FLAG_EN
  logic              w_sat, r_sat_flag;
  assign sat_flag = r_sat_flag;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign w_rdata     = r_rd_pend ? mem.res_di : '0;
  assign w_obj       = r_word[STI_W-1];
  assign w_first_row = (r_row == '0);
  assign w_last_row  = (r_row == LP_RMAX);
  assign w_first_col = (r_col == '0);
  assign w_last_col  = (r_col == LP_CMAX);
  assign w_first_pix = (r_pix == '0);
  assign w_last_pix  = (r_pix == LP_LAST);
  assign w_fwd_val   = w_obj ? w_cand : '0;
  assign w_new       = (w_cand < r_own) ? w_cand : r_own;

  // forward uses W/N/NW/NE, backward E/S/SE/SW; the fourth operand is always the last RAM read
  always_comb begin
    if (r_state == ST_FWD_WR) begin
      w_a = r_w;
      w_b = r_n;
      w_c = r_nw;
    end else begin
      w_a = r_e;
      w_b = r_s;
      w_c = r_se;
    end
  end

  dt_min_sat #(.DIST_W(DIST_W)) u_min_sat (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_c    (w_c),
    .i_d    (w_rdata),
    .i_city (r_mode == MODE_CITY),
`ifdef DT_SAT_FLAG_EN
    .o_sat  (w_sat),
`endif
    .o_res  (w_cand)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_nx;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_phase_nx   = r_phase;
    mem.sti_rd   = 1'b0;
    mem.sti_addr = '0;
    mem.res_rd   = 1'b0;
    mem.res_wr   = 1'b0;
    mem.res_addr = '0;
    mem.res_do   = '0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_FWD_FETCH;
      ST_FWD_FETCH: begin
        mem.sti_rd   = 1'b1;
        mem.sti_addr = r_sti;
        w_next       = ST_FWD_RD;
        w_phase_nx   = 2'd0;
      end
      ST_FWD_RD: begin
        if (r_phase == 2'd0) begin
          mem.res_rd   = !w_first_row;
          mem.res_addr = r_pix - LP_W;
          w_phase_nx   = 2'd1;
        end else begin
          mem.res_rd   = !w_first_row && !w_last_col;
          mem.res_addr = r_pix - LP_WM1;
          w_next       = ST_FWD_WR;
        end
      end
      ST_FWD_WR: begin
        mem.res_wr   = 1'b1;
        mem.res_addr = r_pix;
        mem.res_do   = w_fwd_val;
        w_phase_nx   = 2'd0;
        if (w_last_pix)             w_next = ST_BWD_RD;
        else if (r_bit == LP_BMAX)  w_next = ST_FWD_FETCH;
        else                        w_next = ST_FWD_RD;
      end
      ST_BWD_RD: begin
        if (r_phase == 2'd0) begin
          mem.res_rd   = 1'b1;
          mem.res_addr = r_pix;
          w_phase_nx   = 2'd1;
        end else if (r_phase == 2'd1) begin
          mem.res_rd   = !w_last_row;
          mem.res_addr = r_pix + LP_W;
          w_phase_nx   = 2'd2;
        end else begin
          mem.res_rd   = !w_last_row && !w_first_col;
          mem.res_addr = r_pix + LP_WM1;
          w_next       = ST_BWD_WR;
        end
      end
      ST_BWD_WR: begin
        mem.res_addr = r_pix;
        if ((r_own != '0) && (w_cand < r_own)) begin
          mem.res_wr = 1'b1;
          mem.res_do = w_cand;
        end
        w_phase_nx = 2'd0;
        w_next     = w_first_pix ? ST_FIN : ST_BWD_RD;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix <= '0; r_col <= '0; r_row <= '0; r_bit <= '0; r_sti <= '0; r_word <= '0;
      r_mode <= MODE_CHESS; r_sti_pend <= 1'b0; r_rd_pend <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0;
      r_w <= '0; r_nw <= '0; r_n <= '0; r_own <= '0; r_s <= '0; r_e <= '0; r_se <= '0;
`ifdef DT_SAT_FLAG_EN
      r_sat_flag <= 1'b0;
`endif
    end else begin
      r_sti_pend <= mem.sti_rd;
      r_rd_pend  <= mem.res_rd;
      if (r_sti_pend) r_word <= mem.sti_di;
      case (r_state)
        ST_IDLE: if (start) begin
          r_mode <= mode; r_busy <= 1'b1; r_done <= 1'b0;
          r_pix <= '0; r_col <= '0; r_row <= '0; r_bit <= '0; r_sti <= '0;
          r_w <= '0; r_nw <= '0;
`ifdef DT_SAT_FLAG_EN
          r_sat_flag <= 1'b0;
`endif
        end
        ST_FWD_FETCH: r_sti <= r_sti + STI_AW'(1);
        ST_FWD_RD: if (r_phase == 2'd1) r_n <= w_rdata;
        ST_FWD_WR: begin
          r_word <= r_word << 1;
          r_w    <= w_last_col ? '0 : w_fwd_val;
          r_nw   <= w_last_col ? '0 : r_n;
`ifdef DT_SAT_FLAG_EN
          if (w_obj && w_sat) r_sat_flag <= 1'b1;
`endif
          if (w_last_pix) begin
            r_e  <= '0;
            r_se <= '0;
          end else begin
            r_pix <= r_pix + RES_AW'(1);
            r_bit <= (r_bit == LP_BMAX) ? '0 : r_bit + BW'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ST_BWD_RD: begin
          if (r_phase == 2'd1) r_own <= w_rdata;
          if (r_phase == 2'd2) r_s   <= w_rdata;
        end
        ST_BWD_WR: begin
          r_e  <= w_first_col ? '0 : w_new;
          r_se <= w_first_col ? '0 : r_s;
          if (!w_first_pix) begin
            r_pix <= r_pix - RES_AW'(1);
            if (w_first_col) begin
              r_col <= LP_CMAX;
              r_row <= r_row - RW'(1);
            end else begin
              r_col <= r_col - CW'(1);
            end
          end
        end
        ST_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dt_engine_param.sv
// Bench for dt_engine_param: random and directed images against a brute-force distance model.
module tb_dt_engine_param;
  localparam int unsigned W = 32, H = 16, SW = 16, DW = 3;
  localparam int unsigned NPIX = W*H, NWORD = NPIX/SW;
  localparam int unsigned SAW = $clog2(NWORD), RAW = $clog2(NPIX);
  localparam int MAXV   = (1 << DW) - 1;
  localparam int BUDGET = 8*NPIX + 8;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic busy, done;
`ifdef DT_SAT_FLAG_EN
  logic sat_flag;
`endif

  dt_engine_param_if #(.STI_AW(SAW), .STI_W(SW), .RES_AW(RAW), .DIST_W(DW)) mem_if ();

  dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
`ifdef DT_SAT_FLAG_EN
    .sat_flag (sat_flag),
`endif
    .mem   (mem_if)
  );

  bit              img [NPIX];
  logic [SW-1:0]   rom [NWORD];
  logic [DW-1:0]   ram [NPIX];
  bit              fill_req = 1'b0;
  int              n_checks = 0, n_err = 0;
  int              viol = 0, sti_cnt = 0;
  bit              fwd_done = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= DW'($urandom);
    end else begin
      if (mem_if.sti_rd) mem_if.sti_di <= rom[mem_if.sti_addr];
      if (mem_if.res_rd) mem_if.res_di <= ram[mem_if.res_addr];
      if (mem_if.res_wr) ram[mem_if.res_addr] <= mem_if.res_do;
    end
  end

  // bus rules: no read+write together, no ROM after the forward pass,
  // backward writes only ever lower an object pixel
  always @(negedge clk) begin
    if (mem_if.res_rd && mem_if.res_wr) viol++;
    if (mem_if.sti_rd) begin
      sti_cnt++;
      if (fwd_done) viol++;
    end
    if (mem_if.res_wr && fwd_done)
      if (!img[mem_if.res_addr] || mem_if.res_do >= ram[mem_if.res_addr]) viol++;
    if (mem_if.res_wr && mem_if.res_addr == RAW'(NPIX-1)) fwd_done = 1'b1;
    if (!busy) fwd_done = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // nearest background by brute force; outside the image counts as background
  function automatic int ref_dist(int idx, bit city);
    int r, c, d, dr, dc, t;
    if (!img[idx]) return 0;
    r = idx / W;
    c = idx % W;
    d = r + 1;
    if (H - r < d) d = H - r;
    if (c + 1 < d) d = c + 1;
    if (W - c < d) d = W - c;
    for (int j = 0; j < NPIX; j++) begin
      if (!img[j]) begin
        dr = (j / W > r) ? j / W - r : r - j / W;
        dc = (j % W > c) ? j % W - c : c - j % W;
        t  = city ? dr + dc : ((dr > dc) ? dr : dc);
        if (t < d) d = t;
      end
    end
    return (d > MAXV) ? MAXV : d;
  endfunction

`ifdef DT_SAT_FLAG_EN
  // forward-only unclamped values; any above MAXV means the forward pass clamped
  function automatic bit exp_sat(bit city);
    int f [NPIX];
    int m, r, c;
    bit s;
    s = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      r = i / W;
      c = i % W;
      if (!img[i]) f[i] = 0;
      else begin
        m = (c > 0) ? f[i-1] : 0;
        if (r == 0) m = 0;
        else if (f[i-W] < m) m = f[i-W];
        if (!city) begin
          if (r == 0 || c == 0) m = 0;
          else if (f[i-W-1] < m) m = f[i-W-1];
          if (r == 0 || c == W-1) m = 0;
          else if (f[i-W+1] < m) m = f[i-W+1];
        end
        f[i] = m + 1;
        if (f[i] > MAXV) s = 1'b1;
      end
    end
    return s;
  endfunction
`endif

  task automatic make_img(input int kind, input int p);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = 1'b0;
        1:       img[i] = 1'b1;
        2:       img[i] = (i != 2*W + 2);
        3:       img[i] = ($urandom_range(7) < p);
        default: img[i] = (i == (H/2)*W + W/2);
      endcase
    end
  endtask

  task automatic prep();
    logic [SW-1:0] v;
    for (int w = 0; w < NWORD; w++) begin
      v = '0;
      for (int b = 0; b < SW; b++) v[SW-1-b] = img[w*SW + b];
      rom[w] = v;
    end
    fill_req = 1'b1;
    @(posedge clk);
    #1 fill_req = 1'b0;
  endtask

  task automatic run_job(input bit city, input bit pulses);
    int n, v0, s0;
    prep();
    @(negedge clk);
    v0 = viol;
    s0 = sti_cnt;
    start = 1'b1;
    mode  = city;
    @(negedge clk);
    start = 1'b0;
    mode  = ~city;
    chk("busy_on_start", busy, 1);
    chk("done_clear_on_start", done, 0);
    n = 0;
    while (!done && n < BUDGET) begin
      start = pulses && (n == 40 || n == 2000);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_within_budget", done, 1);
    chk("busy_off_at_done", busy, 0);
    chk("bus_rules", viol - v0, 0);
    chk("rom_reads", sti_cnt - s0, NWORD);
    for (int i = 0; i < NPIX; i++) chk($sformatf("pix%0d", i), ram[i], ref_dist(i, city));
`ifdef DT_SAT_FLAG_EN
    chk("sat_flag", sat_flag, exp_sat(city));
`endif
    @(negedge clk);
    chk("done_held", done, 1);
  endtask

  initial begin
    #12;
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_strobes", {mem_if.sti_rd, mem_if.res_rd, mem_if.res_wr}, 0);
    chk("rst_addr_data", {mem_if.sti_addr, mem_if.res_addr, mem_if.res_do}, 0);
`ifdef DT_SAT_FLAG_EN
    chk("rst_sat_flag", sat_flag, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    make_img(0, 0); run_job(1'b0, 1'b0);
    make_img(1, 0); run_job(1'b0, 1'b0);
    run_job(1'b1, 1'b0);
    make_img(2, 0); run_job(1'b0, 1'b0);
    run_job(1'b1, 1'b0);
    make_img(5, 0); run_job(1'b0, 1'b0);
    make_img(3, 6); run_job(1'b0, 1'b1);
    make_img(3, 6); run_job(1'b1, 1'b1);

    // asynchronous reset in the middle of the forward pass
    make_img(3, 7);
    prep();
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy_done", {busy, done}, 0);
    chk("midrst_strobes", {mem_if.sti_rd, mem_if.res_rd, mem_if.res_wr}, 0);
    chk("midrst_addr_data", {mem_if.sti_addr, mem_if.res_addr, mem_if.res_do}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_job(1'b0, 1'b0);

    make_img(3, 4); run_job(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
